dmem_bytelane: RTL and testbench
================================

DMEM_BYTELANE -- requirements
Module: dmem_bytelane

Interface
REQ-001 Parameter DEPTH, default 1024: memory size in 32-bit words; power of two, 16..65536.
REQ-002 Parameter INIT_FILE, default "": if non-empty, hex image loaded into the array at elaboration; otherwise contents are undefined.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 Port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0; ignored for stores and word loads.
REQ-010 Port req_addr  input  32  byte address.
REQ-011 Port req_wdata  input  32  store data; byte/half taken from bits [7:0]/[15:0].
REQ-012 Port rsp_valid  output  1  response present.
REQ-013 Port rsp_ready  input  1  response consumed this cycle when high together with rsp_valid.
REQ-014 Port rsp_rdata  output  32  load result; 0 for stores and errored requests.
REQ-015 Port rsp_err  output  1  request was misaligned, illegal-size or out of range.
REQ-016 Port err_count  output  16  number of errored requests accepted since reset, saturating.

Function
REQ-017 Accept = req_valid && req_ready; req_ready = !rsp_valid || rsp_ready (combinational; no combinational path from req_* to req_ready).
REQ-018 Latency: request accepted at edge N -> rsp_valid high from edge N (visible in cycle N+1); exactly one response per accepted request, in order.
REQ-019 Response hold: while rsp_valid && !rsp_ready, rsp_valid/rsp_rdata/rsp_err stay constant.
REQ-020 Back-to-back: rsp_ready high with a new accept in the same cycle -> old response retires and new response is loaded at that edge, no bubble.
REQ-021 rsp_valid clears at an edge where rsp_ready is high and no new accept occurs.
REQ-022 Word index = req_addr[31:2]; lane = req_addr[1:0].
REQ-023 Error if any holds: req_size==3; size 1 with lane[0]==1; size 2 with lane!=0; word index >= DEPTH.
REQ-024 Errored request: no memory write, rsp_err=1, rsp_rdata=0, err_count increments (holds at 16'hFFFF).
REQ-025 Byte store: only byte lane `lane` written with req_wdata[7:0]; the other three bytes are unchanged.
REQ-026 Half store: lanes lane and lane+1 written with req_wdata[15:0], little-endian; other bytes unchanged.
REQ-027 Word store: all four bytes written with req_wdata.
REQ-028 Stores respond with rsp_err=0, rsp_rdata=0.
REQ-029 Loads: selected byte/half shifted to bits [7:0]/[15:0], then extended per req_unsigned; word loads are returned unmodified.
REQ-030 Read-after-write: a load accepted the cycle after a store to the same word returns the post-store data.
REQ-031 Memory is a single-port synchronous array; read and write never occur in the same cycle (one request per cycle).

Reset
REQ-032 While rst is high at an edge: rsp_valid=0, rsp_err=0, rsp_rdata=0, err_count=0; any accepted-but-unretired response is discarded.
REQ-033 Reset does not modify memory contents; a request presented while rst is high is not accepted and has no effect.
REQ-034 req_ready is high in the first cycle after reset deasserts.

Verification
REQ-035 SW 0x11223344 @0x40, then LW @0x40 -> rsp_rdata=0x11223344, rsp_err=0, each response one cycle after its accept.
REQ-036 After REQ-035, SB 0xAB @0x41, then LW @0x40 -> 0x1122AB44; LB @0x41 -> 0xFFFFFFAB; LBU @0x41 -> 0x000000AB.
REQ-037 SH 0x8001 @0x46, then LH @0x46 -> 0xFFFF8001 and LHU -> 0x00008001; LH @0x45 -> rsp_err=1, rdata=0, err_count=1, memory unchanged.
REQ-038 LW @0x42, LW @(4*DEPTH), req_size=3 in sequence -> three rsp_err=1 responses, err_count=3, no writes; 65540 errors -> err_count=0xFFFF.
REQ-039 Hold rsp_ready=0 for 5 cycles with req_valid=1 -> req_ready=0, response stable; then rsp_ready=1 every cycle with back-to-back loads -> one response per cycle, in order.
REQ-040 Assert rst while rsp_valid=1 -> next cycle rsp_valid=0, err_count=0, req_ready=1; a subsequent load of a previously stored word returns the stored data.

Source files
------------

// File: rtl/dmem_bytelane.sv
// Single-port byte-lane data memory with a valid/ready request channel and a
// one-entry registered response slot; misaligned, illegal or out-of-range requests error out.
module dmem_bytelane #(
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] err_count
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          req_err;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   wword;

    logic [31:0]   rd_word;
    logic          rsp_load;
    logic [1:0]    rsp_size;
    logic [1:0]    rsp_lane;
    logic          rsp_unsigned;
    logic [31:0]   shifted;

    // Handshake: a request is taken when req_valid && req_ready; the single
    // response slot frees up when it is empty or being consumed this cycle.
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready && !rst;

    assign lane = req_addr[1:0];
    assign idx  = req_addr[AW+1:2];

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'd0:    req_err = 1'b0;
            2'd1:    req_err = lane[0];
            2'd2:    req_err = (lane != 2'd0);
            default: req_err = 1'b1;
        endcase
        if (req_addr[31:2] >= 30'(DEPTH)) begin
            req_err = 1'b1;
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        be    = 4'b0000;
        wword = req_wdata;
        case (req_size)
            2'd0: begin
                be    = 4'b0001 << lane;
                wword = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be    = 4'b0011 << lane;
                wword = {2{req_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && !req_err) begin
            if (req_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wword[8*i +: 8];
                    end
                end
            end else begin
                rd_word <= mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_load  <= 1'b0;
            err_count <= 16'h0000;
        end else if (accept) begin
            rsp_valid    <= 1'b1;
            rsp_err      <= req_err;
            rsp_load     <= !req_we && !req_err;
            rsp_size     <= req_size;
            rsp_lane     <= lane;
            rsp_unsigned <= req_unsigned;
            if (req_err && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Lane extraction happens after the registered read so the array maps onto a plain RAM.
    assign shifted = rd_word >> {rsp_lane, 3'b000};

    always_comb begin
        rsp_rdata = 32'h0;
        if (rsp_load) begin
            case (rsp_size)
                2'd0:    rsp_rdata = rsp_unsigned ? {24'h0, shifted[7:0]}
                                                  : {{24{shifted[7]}}, shifted[7:0]};
                2'd1:    rsp_rdata = rsp_unsigned ? {16'h0, shifted[15:0]}
                                                  : {{16{shifted[15]}}, shifted[15:0]};
                default: rsp_rdata = rd_word;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: directed vector table, stall/back-to-back/reset
// sequences, and randomized traffic against a byte-array reference model.
module tb_dmem_bytelane;

    localparam int DEPTH = 64;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] err_count;

    dmem_bytelane #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  mbytes [NBYTES];
    logic [32:0] exp_q [$];
    int          model_err;
    int          n_checks;
    int          n_fail;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t tv [23];

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {err, rdata}; applies stores to the byte array.
    function automatic logic [32:0] model_apply(input logic we, input logic [1:0] size,
                                                input logic uns, input logic [31:0] addr,
                                                input logic [31:0] wdata);
        int          n;
        logic [31:0] v;
        logic        err;
        n   = 1 << size;
        err = (size == 2'd3) || ((addr % n) != 0) || (addr >= NBYTES);
        if (err) return {1'b1, 32'h0};
        if (we) begin
            for (int i = 0; i < n; i++) mbytes[addr + i] = wdata[8*i +: 8];
            return {1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mbytes[addr + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return {1'b0, v};
    endfunction

    // One clock cycle: drive, check outputs against model, advance the model.
    task automatic do_cycle(input logic v, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic rr, input logic r);
        logic        acc;
        logic [32:0] res;
        req_valid = v; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; rsp_ready = rr; rst = r;
        #1;
        if (!r) begin
            check("req_ready", 32'(req_ready), 32'(exp_q.size() == 0 || rr));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0 && rsp_valid) begin
                check("rsp_rdata", rsp_rdata, exp_q[0][31:0]);
                check("rsp_err", 32'(rsp_err), 32'(exp_q[0][32]));
            end
            check("err_count", 32'(err_count), 32'(model_err));
        end
        if (r) begin
            exp_q.delete();
            model_err = 0;
        end else begin
            acc = v && (exp_q.size() == 0 || rr);
            if (exp_q.size() != 0 && rr) void'(exp_q.pop_front());
            if (acc) begin
                res = model_apply(we, size, uns, addr, wdata);
                exp_q.push_back(res);
                if (res[32] && model_err < 16'hFFFF) model_err++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, rr, 1'b0);
    endtask

    task automatic load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                        input logic rr);
        do_cycle(1'b1, 1'b0, size, uns, addr, 32'h0, rr, 1'b0);
    endtask

    function automatic logic [31:0] model_word(input int a);
        return {mbytes[a + 3], mbytes[a + 2], mbytes[a + 1], mbytes[a]};
    endfunction

    initial begin
        logic [1:0]  s;
        logic [31:0] a;
        int          k;
        n_checks = 0; n_fail = 0; model_err = 0;

        // Reset and reset-state checks
        do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        do_cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 1'b1, 1'b1);
        rst = 1'b0; req_valid = 1'b0; #1;
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_err", 32'(rsp_err), 32'h0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset err_count", 32'(err_count), 32'h0);
        check("reset req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);

        // Fill memory so every later load has a known value
        for (int i = 0; i < DEPTH; i++)
            do_cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, 1'b1, 1'b0);
        idle(1'b1);

        // Directed vector table
        tv[0]  = mk(1, 2, 0, 32'h40, 32'h11223344, 32'h0, 0);
        tv[1]  = mk(0, 2, 0, 32'h40, 32'h0, 32'h11223344, 0);
        tv[2]  = mk(1, 0, 0, 32'h41, 32'h123456AB, 32'h0, 0);
        tv[3]  = mk(0, 2, 0, 32'h40, 32'h0, 32'h1122AB44, 0);
        tv[4]  = mk(0, 0, 0, 32'h41, 32'h0, 32'hFFFFFFAB, 0);
        tv[5]  = mk(0, 0, 1, 32'h41, 32'h0, 32'h000000AB, 0);
        tv[6]  = mk(1, 2, 0, 32'h44, 32'h55667788, 32'h0, 0);
        tv[7]  = mk(1, 1, 0, 32'h46, 32'hDEAD8001, 32'h0, 0);
        tv[8]  = mk(0, 1, 0, 32'h46, 32'h0, 32'hFFFF8001, 0);
        tv[9]  = mk(0, 1, 1, 32'h46, 32'h0, 32'h00008001, 0);
        tv[10] = mk(0, 1, 0, 32'h45, 32'h0, 32'h0, 1);
        tv[11] = mk(0, 2, 0, 32'h44, 32'h0, 32'h80017788, 0);
        tv[12] = mk(0, 2, 0, 32'h42, 32'h0, 32'h0, 1);
        tv[13] = mk(0, 2, 0, 32'(NBYTES), 32'h0, 32'h0, 1);
        tv[14] = mk(0, 3, 0, 32'h40, 32'h0, 32'h0, 1);
        tv[15] = mk(0, 0, 0, 32'h47, 32'h0, 32'hFFFFFF80, 0);
        tv[16] = mk(0, 1, 1, 32'h44, 32'h0, 32'h00007788, 0);
        tv[17] = mk(0, 0, 0, 32'h44, 32'h0, 32'hFFFFFF88, 0);
        tv[18] = mk(1, 2, 0, 32'(NBYTES - 4), 32'hA5A5A5A5, 32'h0, 0);
        tv[19] = mk(0, 2, 0, 32'(NBYTES - 4), 32'h0, 32'hA5A5A5A5, 0);
        tv[20] = mk(1, 2, 0, 32'hFFFFFFFC, 32'h01020304, 32'h0, 1);
        tv[21] = mk(1, 0, 0, 32'h43, 32'h0000007F, 32'h0, 0);
        tv[22] = mk(0, 0, 0, 32'h43, 32'h0, 32'h0000007F, 0);

        for (int i = 0; i < 23; i++) begin
            do_cycle(1'b1, tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, 1'b1, 1'b0);
            check($sformatf("vec%0d valid", i), 32'(rsp_valid), 32'h1);
            check($sformatf("vec%0d rdata", i), rsp_rdata, tv[i].rdata);
            check($sformatf("vec%0d err", i), 32'(rsp_err), 32'(tv[i].err));
        end
        idle(1'b1);
        check("table err_count", 32'(err_count), 32'd5);
        check("table word 0x40", model_word(32'h40), 32'h7F22AB44);

        // Stall: response held while req_valid stays high, then back-to-back loads
        load(2'd2, 1'b0, 32'h40, 1'b1);
        for (int i = 0; i < 5; i++) begin
            load(2'd2, 1'b0, 32'h44, 1'b0);
            check("stall req_ready", 32'(req_ready), 32'h0);
            check("stall rdata", rsp_rdata, 32'h7F22AB44);
        end
        for (int i = 0; i < 8; i++) load(2'd2, 1'b0, 32'(4 * i), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 9);
            s = (k < 9) ? 2'(k % 3) : 2'd3;
            a = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 7));
            do_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), s,
                     1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3) != 0, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        // Error counter saturation
        do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 65540; i++) load(2'd3, 1'b0, 32'h0, 1'b1);
        idle(1'b1);
        check("saturated err_count", 32'(err_count), 32'h0000FFFF);

        // Reset with a pending response, then memory must still hold its data
        load(2'd2, 1'b0, 32'h40, 1'b0);
        do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        rst = 1'b0; #1;
        check("post-reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("post-reset err_count", 32'(err_count), 32'h0);
        check("post-reset req_ready", 32'(req_ready), 32'h1);
        check("post-reset rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        load(2'd2, 1'b0, 32'h40, 1'b1);
        check("reload after reset", rsp_rdata, model_word(32'h40));
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
